// File: rtl/cnn_pkg.sv
// Shared defaults, types and width helpers for the streaming convolution datapath.
package cnn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NUM_CH_DEF = 8;
  localparam int KLEN_DEF   = 3;
  localparam int FRAC_W_DEF = 8;
  localparam int OUT_W_DEF  = 16;
  localparam int ACC_W_DEF  = 40;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;
  typedef logic signed [DATA_W_DEF-1:0] weight_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_t;

  // Index width that never collapses to zero bits for tiny sizes.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_round_sat.sv
// Combinational post-processing: round-half-up, arithmetic shift, optional ReLU, saturate.
module cnn_round_sat
  import cnn_pkg::*;
#(
  parameter int ACC_W  = cnn_pkg::ACC_W_DEF,
  parameter int OUT_W  = cnn_pkg::OUT_W_DEF,
  parameter int FRAC_W = cnn_pkg::FRAC_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic                    relu_i,
  output logic signed [OUT_W-1:0] data_o
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] HALF  = (EXT_W'(1) << FRAC_W) >> 1;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    shifted = (EXT_W'(acc_i) + HALF) >>> FRAC_W;
    if (relu_i && shifted[EXT_W-1]) begin
      shifted = '0;
    end
    if (shifted > MAX_V) begin
      data_o = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      data_o = MIN_V[OUT_W-1:0];
    end else begin
      data_o = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/cnn_conv_stream.sv
// Streaming multi-channel sliding-window convolution with a two-stage stallable pipeline.
module cnn_conv_stream
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W_DEF,
  parameter int NUM_CH = cnn_pkg::NUM_CH_DEF,
  parameter int KLEN   = cnn_pkg::KLEN_DEF,
  parameter int ACC_W  = cnn_pkg::ACC_W_DEF,
  parameter int FRAC_W = cnn_pkg::FRAC_W_DEF,
  parameter int OUT_W  = cnn_pkg::OUT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [clog2_safe(NUM_CH)-1:0] cfg_ch,
  input  logic [clog2_safe(KLEN)-1:0]   cfg_tap,
  input  logic signed [DATA_W-1:0]      cfg_wdata,
  input  logic                          relu_en,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [NUM_CH*DATA_W-1:0]      s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [OUT_W-1:0]       m_data,
  output logic                          m_last,
  output logic                          busy
);

  localparam int TAP_W  = clog2_safe(KLEN);
  localparam int PROD_W = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  smp_t  win_q  [NUM_CH][KLEN];
  smp_t  win_d  [NUM_CH][KLEN];
  smp_t  wgt_q  [NUM_CH][KLEN];
  prod_t prod_q [NUM_CH][KLEN];

  logic [TAP_W-1:0]        fill_q;
  logic                    s1_valid_q, s1_last_q, s1_relu_q;
  logic                    m_valid_q, m_last_q;
  logic signed [OUT_W-1:0] m_data_q, rs_data;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    en, accept, full, emit, cfg_ok;

  assign en      = !m_valid_q | m_ready;
  assign s_ready = en;
  assign accept  = s_valid & en;
  assign full    = (fill_q == TAP_W'(KLEN - 1));
  assign emit    = accept & full;
  assign busy    = (fill_q != '0) | s1_valid_q | m_valid_q;
  assign cfg_ok  = cfg_we & !busy & (32'(cfg_ch) < NUM_CH) & (32'(cfg_tap) < KLEN);

  // Window as it will look after this accept; stage 1 multiplies against it directly.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      win_d[c][0] = s_data[c*DATA_W +: DATA_W];
      for (int k = 1; k < KLEN; k++) begin
        win_d[c][k] = win_q[c][k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < KLEN; k++) begin
          win_q[c][k] <= '0;
          wgt_q[c][k] <= '0;
        end
      end
    end else begin
      if (accept) begin
        win_q <= win_d;
        if (s_last) begin
          fill_q <= '0;
        end else if (!full) begin
          fill_q <= fill_q + TAP_W'(1);
        end
      end
      if (cfg_ok) begin
        wgt_q[cfg_ch][cfg_tap] <= cfg_wdata;
      end
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < KLEN; k++) begin
        acc_sum = acc_sum + ACC_W'(prod_q[c][k]);
      end
    end
  end

  cnn_round_sat #(
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .FRAC_W (FRAC_W)
  ) u_round_sat (
    .acc_i  (acc_sum),
    .relu_i (s1_relu_q),
    .data_o (rs_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_relu_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < KLEN; k++) begin
          prod_q[c][k] <= '0;
        end
      end
    end else if (en) begin
      s1_valid_q <= emit;
      if (emit) begin
        s1_last_q <= s_last;
        s1_relu_q <= relu_en;
        for (int c = 0; c < NUM_CH; c++) begin
          for (int k = 0; k < KLEN; k++) begin
            prod_q[c][k] <= PROD_W'(wgt_q[c][k]) * PROD_W'(win_d[c][k]);
          end
        end
      end
      m_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        m_data_q <= rs_data;
        m_last_q <= s1_last_q;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_cnn_conv_stream.sv
// Self-checking bench for cnn_conv_stream: directed vector table, corner sequences and a randomized run.
module tb_cnn_conv_stream;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 8;
  localparam int KLEN   = 3;
  localparam int FRAC_W = 8;
  localparam int OUT_W  = 16;
  localparam int ACC_W  = 40;
  localparam int SW     = NUM_CH * DATA_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    cfg_we = 1'b0;
  logic [2:0]              cfg_ch = '0;
  logic [1:0]              cfg_tap = '0;
  logic [15:0]             cfg_wdata = '0;
  logic                    relu_en = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_last = 1'b0;
  logic [SW-1:0]           s_data = '0;
  logic                    m_ready = 1'b1;
  logic                    s_ready, m_valid, m_last, busy;
  logic signed [OUT_W-1:0] m_data;

  always #5 clk = ~clk;

  cnn_conv_stream #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .KLEN(KLEN),
    .ACC_W(ACC_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_tap(cfg_tap),
    .cfg_wdata(cfg_wdata), .relu_en(relu_en), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  typedef int vec_t [NUM_CH];
  typedef struct { int data; bit last; } res_t;
  typedef struct { int mode; int val; bit relu; int exp; } tv_t;

  vec_t row_q [$];
  res_t exp_q [$];
  res_t got_q [$];
  int   wm [NUM_CH][KLEN];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rnd_done = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: dot product over the last KLEN samples of the current row, then round/relu/clamp.
  function automatic int ref_out(input bit relu);
    longint acc = 0;
    for (int k = 0; k < KLEN; k++)
      for (int c = 0; c < NUM_CH; c++)
        acc += longint'(wm[c][k]) * longint'(row_q[row_q.size()-1-k][c]);
    acc = (acc + longint'(2 ** (FRAC_W - 1))) >>> FRAC_W;
    if (relu && acc < 0) acc = 0;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic model_loop();
    bit   mbusy;
    vec_t v;
    res_t r, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        row_q.delete();
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++)
          for (int k = 0; k < KLEN; k++) wm[c][k] = 0;
      end else begin
        mbusy = (row_q.size() != 0) || (exp_q.size() != 0);
        chk("busy", busy, mbusy);
        if (cfg_we && !mbusy && int'(cfg_ch) < NUM_CH && int'(cfg_tap) < KLEN)
          wm[cfg_ch][cfg_tap] = int'($signed(cfg_wdata));
        if (m_valid && m_ready) begin
          r.data = int'(m_data);
          r.last = m_last;
          got_q.push_back(r);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0d with no result pending", r.data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", r.data, e.data);
            chk("out_last", r.last, e.last);
          end
        end
        if (s_valid && s_ready) begin
          for (int c = 0; c < NUM_CH; c++) v[c] = int'($signed(s_data[c*DATA_W +: DATA_W]));
          row_q.push_back(v);
          if (row_q.size() >= KLEN) begin
            r.data = ref_out(relu_en);
            r.last = s_last;
            exp_q.push_back(r);
          end
          if (s_last) row_q.delete();
        end
      end
    end
  endtask

  function automatic logic [SW-1:0] all_lanes(input int v);
    logic [SW-1:0] d;
    for (int c = 0; c < NUM_CH; c++) d[c*DATA_W +: DATA_W] = 16'(v);
    return d;
  endfunction

  function automatic logic [SW-1:0] lanes2(input int a, input int b);
    logic [SW-1:0] d = '0;
    d[15:0]  = 16'(a);
    d[31:16] = 16'(b);
    return d;
  endfunction

  function automatic logic [SW-1:0] rand_lanes();
    logic [SW-1:0] d;
    for (int c = 0; c < NUM_CH; c++) d[c*DATA_W +: DATA_W] = 16'(int'($urandom_range(0, 2000)) - 1000);
    return d;
  endfunction

  // All drivers below start and end at posedge+1.
  task automatic set_w(input int ch, input int tap, input int val);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_tap = 2'(tap); cfg_wdata = 16'(val);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // mode 0: w[0][0]=256; 1: all 256; 2: w[0][0]=1; 3: w[0][0..2]=256
  task automatic load_weights(input int mode);
    int v;
    for (int c = 0; c < NUM_CH; c++)
      for (int t = 0; t < KLEN; t++) begin
        case (mode)
          1:       v = 256;
          2:       v = (c == 0 && t == 0) ? 1 : 0;
          3:       v = (c == 0) ? 256 : 0;
          default: v = (c == 0 && t == 0) ? 256 : 0;
        endcase
        set_w(c, t, v);
      end
  endtask

  task automatic send(input logic [SW-1:0] d, input bit last, input bit relu);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last; relu_en = relu;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      if (++n > 200) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: s_ready stuck at %0d, required 1", s_ready);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && row_q.size() == 0 && !busy) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL idle_timeout: pending %0d busy %0d, required 0 and 0", exp_q.size(), busy);
    @(posedge clk); #1;
  endtask

  task automatic wait_mvalid();
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (m_valid) return;
    end
    n_checks++; n_fail++;
    $display("FAIL mvalid_timeout: m_valid %0d, required 1", m_valid);
  endtask

  task automatic chk_got(input string name, input int idx, input int data, input bit last);
    if (got_q.size() > idx) begin
      chk({name, "_data"}, got_q[idx].data, data);
      chk({name, "_last"}, got_q[idx].last, last);
    end
  endtask

  tv_t tv [16];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    tv[0]  = '{1,  2000, 0,  32767};
    tv[1]  = '{1, -2000, 0, -32768};
    tv[2]  = '{1, -2000, 1,      0};
    tv[3]  = '{1,  2000, 1,  32767};
    tv[4]  = '{1,    10, 0,    240};
    tv[5]  = '{1,   -10, 0,   -240};
    tv[6]  = '{1,   -10, 1,      0};
    tv[7]  = '{1,  1365, 0,  32760};
    tv[8]  = '{1,  1366, 0,  32767};
    tv[9]  = '{1, -1365, 0, -32760};
    tv[10] = '{1, -1366, 0, -32768};
    tv[11] = '{2,   255, 0,      1};
    tv[12] = '{2,   127, 0,      0};
    tv[13] = '{2,   128, 0,      1};
    tv[14] = '{2,  -129, 0,     -1};
    tv[15] = '{2,  -128, 0,      0};

    fork model_loop(); join_none

    #1 rst = 1'b1;
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Reset while a result is being held
    got_q.delete();
    set_w(0, 0, 256);
    m_ready = 1'b0;
    send(lanes2(1, 0), 0, 0);
    send(lanes2(2, 0), 0, 0);
    send(lanes2(3, 0), 0, 0);
    wait_mvalid();
    chk("pre_rst_m_data", m_data, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_m_valid", m_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_m_data", m_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    chk("post_rst_s_ready", s_ready, 1);
    set_w(0, 0, 256);
    send(lanes2(5, 0), 0, 0);
    send(lanes2(6, 0), 0, 0);
    send(lanes2(7, 0), 1, 0);
    wait_idle();
    chk("rst_row_count", got_q.size(), 1);
    chk_got("rst_row", 0, 7, 1);

    // Identity and latency
    load_weights(0);
    got_q.delete();
    send(lanes2(10, 0), 0, 0);
    send(lanes2(20, 0), 0, 0);
    send(lanes2(30, 0), 0, 0);
    chk("lat_1cyc_m_valid", m_valid, 0);
    send(lanes2(40, 0), 1, 0);
    chk("lat_2cyc_m_valid", m_valid, 1);
    chk("lat_2cyc_m_data", m_data, 30);
    wait_idle();
    chk("ident_count", got_q.size(), 2);
    chk_got("ident0", 0, 30, 0);
    chk_got("ident1", 1, 40, 1);

    // Vector table: rounding, ReLU, saturation
    for (int i = 0; i < 16; i++) begin
      load_weights(tv[i].mode);
      got_q.delete();
      for (int s = 0; s < 3; s++)
        send((tv[i].mode == 1) ? all_lanes(tv[i].val) : lanes2(tv[i].val, 0), s == 2, tv[i].relu);
      wait_idle();
      chk($sformatf("vec%0d_count", i), got_q.size(), 1);
      chk_got($sformatf("vec%0d", i), 0, tv[i].exp, 1);
    end

    // Backpressure
    load_weights(0);
    got_q.delete();
    fork
      begin
        for (int s = 1; s <= 6; s++) send(lanes2(s, 0), s == 6, 0);
      end
      begin
        wait_mvalid();
        m_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
          @(negedge clk);
          chk("bp_m_valid", m_valid, 1);
          chk("bp_m_data", m_data, 3);
          chk("bp_s_ready", s_ready, 0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_got($sformatf("bp%0d", i), i, i + 3, i == 3);

    // Short row, then a fresh row
    load_weights(3);
    got_q.delete();
    send(lanes2(100, 0), 0, 0);
    send(lanes2(200, 0), 1, 0);
    wait_idle();
    chk("short_count", got_q.size(), 0);
    chk("short_busy", busy, 0);
    send(lanes2(1, 0), 0, 0);
    send(lanes2(2, 0), 0, 0);
    send(lanes2(3, 0), 1, 0);
    wait_idle();
    chk("fresh_count", got_q.size(), 1);
    chk_got("fresh", 0, 6, 1);

    // Config gating by busy
    load_weights(0);
    got_q.delete();
    send(lanes2(0, 7), 0, 0);
    set_w(1, 2, 512);
    send(lanes2(0, 0), 0, 0);
    send(lanes2(5, 0), 1, 0);
    wait_idle();
    set_w(0, 3, 999);
    set_w(1, 2, 512);
    send(lanes2(0, 7), 0, 0);
    send(lanes2(0, 0), 0, 0);
    send(lanes2(5, 0), 1, 0);
    wait_idle();
    chk("gate_count", got_q.size(), 2);
    chk_got("gate_busy", 0, 5, 1);
    chk_got("gate_idle", 1, 19, 1);

    // Randomized traffic against the model
    fork
      begin
        for (int r = 0; r < 40; r++) begin
          if (r % 10 == 0) begin
            wait_idle();
            for (int c = 0; c < NUM_CH; c++)
              for (int t = 0; t < KLEN; t++) set_w(c, t, int'($urandom_range(0, 600)) - 300);
          end
          len = int'($urandom_range(1, 7));
          for (int s = 0; s < len; s++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
              @(posedge clk); #1;
            end
            if ($urandom_range(0, 7) == 0)
              set_w(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 600)) - 300);
            send(rand_lanes(), s == len - 1, 1'($urandom_range(0, 1)));
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    wait_idle();
    chk("final_pending", exp_q.size(), 0);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_conv_stream.md
Name: cnn_conv_stream

Overview:
- Parametrised streaming successor to the fixed 8x32 array-port convolution top.
- Accepts one multi-channel sample vector per handshake and keeps a KLEN-deep sliding window per channel.
- Produces one fixed-point dot-product output per accepted sample once the window is full, using weights held in an internal register file.
- Two-stage pipeline with valid/ready backpressure, optional ReLU, rounding and saturation. Sits between the feature-map reader and the pooling/writeback stage.

Parameters:
- DATA_W, 16: signed sample and weight width.
- NUM_CH, 8: input channels (parallel lanes).
- KLEN, 3: taps per channel (window depth); KLEN must be at least 2.
- ACC_W, 40: signed accumulator width; must be at least 2*DATA_W + clog2(NUM_CH*KLEN).
- FRAC_W, 8: weight fraction bits; the result is shifted right by FRAC_W.
- OUT_W, 16: signed output width.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous reset, active-high.
- cfg_we, in, 1: weight write strobe.
- cfg_ch, in, clog2(NUM_CH): channel index of the weight write.
- cfg_tap, in, clog2(KLEN): tap index of the weight write.
- cfg_wdata, in, DATA_W: signed weight value.
- relu_en, in, 1: clamp negative results to 0; sampled with each accepted input.
- s_valid, in, 1: input sample valid.
- s_ready, out, 1: input ready.
- s_data, in, NUM_CH*DATA_W: one signed sample per channel; ch0 in the LSBs.
- s_last, in, 1: last sample of the row.
- m_valid, out, 1: output valid.
- m_ready, in, 1: downstream ready.
- m_data, out, OUT_W: signed result.
- m_last, out, 1: result belongs to the s_last sample.
- busy, out, 1: window non-empty or pipeline holds data.

Behaviour:
- **Reset:** while rst=1, asynchronously clear:
  - all weights, windows, fill_cnt and stage valid flags;
  - m_valid=0, m_data=0, m_last=0, busy=0.
  - s_ready reads 1 after reset.
- **Stall enable:** en = !m_valid | m_ready.
  - s_ready = en, combinational.
  - Every pipeline register and window advances only when en=1.
  - Accept occurs when s_valid & s_ready.
- **Window:** w[ch][0] holds the newest sample. On accept, shift w[ch][k] <= w[ch][k-1] and load w[ch][0] <= s_data lane ch.
- **Fill and emit:**
  - fill_cnt counts 0..KLEN-1.
  - An accept with fill_cnt < KLEN-1 increments the counter and emits nothing.
  - An accept with fill_cnt = KLEN-1 emits one result ("valid" convolution). A row of N samples (N >= KLEN) therefore yields N-KLEN+1 results.
- **End of row (s_last):**
  - After the s_last accept, fill_cnt returns to 0 in the same cycle.
  - If that accept emits a result, the result carries m_last=1.
  - If the window was not yet full, nothing is emitted and no m_last is produced.
  - The next row starts from an empty window; old window contents are never used again.
- **Stage 1** (registered on an emitting accept):
  - NUM_CH*KLEN signed products weight[ch][k]*window[ch][k], using the just-updated window.
  - Also registers last and relu flags and s1_valid.
- **Stage 2** (registered):
  - Adder tree sum in ACC_W, sign-extended.
  - Add 2^(FRAC_W-1) (skip this if FRAC_W=0), then arithmetic shift right by FRAC_W.
  - If relu then max(0, value).
  - Saturate to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Result is driven on m_data/m_valid/m_last.
- **Latency and throughput:** m_valid rises 2 cycles after the emitting accept when m_ready=1. Throughput is one result per cycle.
- **Backpressure:** with m_valid=1 and m_ready=0, m_data and m_last hold stable, s_ready=0, and no data is lost or duplicated.
- **Weight writes:**
  - Applied on the clk edge when cfg_we=1 and busy=0.
  - When busy=1 the write is dropped silently.
  - Out-of-range cfg_ch or cfg_tap (non-power-of-two sizes) is dropped.
  - cfg_we and s_valid in the same cycle with busy=0: the write takes effect and the sample is accepted. The sample's product uses the old weight only if the window was already full, which is impossible with busy=0, so no conflict arises.
- **busy:** busy = (fill_cnt != 0) | s1_valid | m_valid.

Decomposition:
- **Package cnn_pkg:** default constants (DATA_W, NUM_CH, KLEN, FRAC_W, OUT_W, ACC_W); typedefs sample_t, weight_t, acc_t; function clog2_safe.
- **Sub-module cnn_round_sat:** combinational round, shift, ReLU and saturate stage (ACC_W in, OUT_W out), reused later by the pooling block.

Test Plan:
1. Reset during operation: rst=1 mid-row with m_valid=1 -> m_valid/busy/m_data drop to 0 without waiting for a clock edge; s_ready=1 after release; a following row with weight w[0][0]=256 and x0=5,6,7 yields 7 only.
2. Identity (FRAC_W=8, w[0][0]=256, others 0, all lanes but ch0 = 0): ch0 = 10,20,30,40 with s_last on 40 -> results 30 and 40, m_last on 40 only, first m_valid exactly 2 cycles after the third accept.
3. Saturation and ReLU (all 24 weights 256):
   - 3 samples of all lanes = 2000 -> sum 48000 -> m_data = 32767.
   - All lanes = -2000 -> -32768.
   - Same with relu_en=1 -> 0.
   - x=255 on ch0 only with w[0][0]=1 -> rounding gives 1.
4. Backpressure: 6-sample row, m_ready low for 5 cycles after the first result -> m_data stable, s_ready=0, all 4 results delivered in order, none repeated.
5. Short row: s_last on the 2nd sample (KLEN=3) -> no output, busy returns to 0. The next row of 3 samples emits exactly one result, computed without the previous row's samples.
6. Config gating: cfg_we with w[1][2]=512 while busy=1 -> no effect. The same write with busy=0 -> the next row's result reflects 2x ch1's oldest tap.
